imem_loader: RTL



---
 rtl/mips_pkg.sv | 18 +
 rtl/imem_word_assembler.sv | 45 ++++
 rtl/imem_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-side program loader: word geometry and loader states.
package mips_pkg;

   localparam int unsigned INSTR_WIDTH = 32;
   localparam int unsigned WORD_BYTES  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      WRITE  = 3'd4,
      CHECK  = 3'd5,
      DONE   = 3'd6,
      ERROR  = 3'd7
   } loader_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler with byte counter; running XOR of shifted bytes
// exists only when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_word_assembler
   import mips_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clear,
   input  logic                            shift_en,
   input  logic [7:0]                      byte_in,
   output logic [INSTR_WIDTH-1:0]          word,
   output logic [$clog2(WORD_BYTES)-1:0]   byte_count
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]                      xor_sum
`endif
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word       <= '0;
         byte_count <= '0;
      end else if (clear) begin
         word       <= '0;
         byte_count <= '0;
      end else if (shift_en) begin
         // MSB arrives first, so earlier bytes migrate toward the top
         word       <= {word[INSTR_WIDTH-9:0], byte_in};
         byte_count <= byte_count + 1'b1;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xor_sum <= '0;
      end else if (clear) begin
         xor_sum <= '0;
      end else if (shift_en) begin
         xor_sum <= xor_sum ^ byte_in;
      end
   end
`endif

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing big-endian words into instruction memory while holding
// the core. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
   import mips_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
   parameter int unsigned            MAX_WORDS  = 256
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   Start,
   input  logic [7:0]             ByteData,
   input  logic                   ByteValid,
   output logic                   ByteReady,
   output logic [INSTR_WIDTH-1:0] WriteData,
   output logic                   WriteEnable,
   output logic [ADDR_WIDTH-1:0]  WriteAddress,
   output logic                   CoreHold,
   output logic                   LoadDone,
   output logic                   LoadError
);

   localparam int unsigned CNT_W = $clog2(WORD_BYTES);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loader_state_t TAIL_STATE = CHECK;
`else
   localparam loader_state_t TAIL_STATE = DONE;
`endif

   loader_state_t    state;
   logic [7:0]       len_hi;
   logic [15:0]      len;
   logic [15:0]      len_in;
   logic [15:0]      word_count;
   logic [15:0]      word_count_inc;
   logic [CNT_W-1:0] byte_count;
   logic             xfer;
   logic             start_ok;
   logic             shift_en;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   // Status outputs decode straight from the registered state
   assign ByteReady      = state inside {LEN_HI, LEN_LO, DATA, CHECK};
   assign WriteEnable    = (state == WRITE);
   assign CoreHold       = (state != DONE);
   assign LoadDone       = (state == DONE);
   assign LoadError      = (state == ERROR);

   assign xfer           = ByteValid && ByteReady;
   assign start_ok       = Start && (state inside {IDLE, DONE, ERROR});
   assign shift_en       = xfer && (state == DATA);
   assign len_in         = {len_hi, ByteData};
   assign word_count_inc = word_count + 16'd1;

   imem_word_assembler u_asm (
      .clk        (Clk),
      .rst_n      (Rst_n),
      .clear      (start_ok),
      .shift_en   (shift_en),
      .byte_in    (ByteData),
      .word       (WriteData),
      .byte_count (byte_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .xor_sum    (csum)
`endif
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= IDLE;
         len_hi       <= '0;
         len          <= '0;
         word_count   <= '0;
         WriteAddress <= BASE_ADDR;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (Start) begin
                  state        <= LEN_HI;
                  word_count   <= '0;
                  WriteAddress <= BASE_ADDR;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_hi <= ByteData;
                  state  <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len <= len_in;
                  if (32'(len_in) > MAX_WORDS) begin
                     state <= ERROR;
                  end else if (len_in == 16'd0) begin
                     state <= TAIL_STATE;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (shift_en && byte_count == CNT_W'(WORD_BYTES - 1)) begin
                  state <= WRITE;
               end
            end
            WRITE: begin
               WriteAddress <= WriteAddress + ADDR_WIDTH'(WORD_BYTES);
               word_count   <= word_count_inc;
               state        <= (word_count_inc == len) ? TAIL_STATE : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
               if (xfer) begin
                  state <= (ByteData == csum) ? DONE : ERROR;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
